// File: rtl/pmp_pkg.sv
// pmp_pkg
// Shared definitions for the phase-matching pipeline.
//   - wr_state_e : write-side state of the reference row cache.
//   - calc_n_win : windows (cache words) per reference row.
//   - calc_bpw   : input beats per cache window.
//   - calc_bpr   : input beats per reference row.
// The derived sizes are functions so that every instance computes them
// from its own parameter overrides.
package pmp_pkg;

  typedef enum logic [1:0] {
    W_LOAD  = 2'd0,
    W_FULL  = 2'd1,
    W_FLUSH = 2'd2
  } wr_state_e;

  function automatic int calc_n_win(input int row_size, input int win_size);
    return row_size / win_size;
  endfunction

  function automatic int calc_bpw(input int win_size, input int beat_size);
    return win_size / beat_size;
  endfunction

  function automatic int calc_bpr(input int row_size, input int beat_size);
    return row_size / beat_size;
  endfunction

endpackage

// File: rtl/shift_reg.sv
// shift_reg
// Fixed-depth pipeline delay with asynchronous active-high reset to zero.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears every stage
//   d   : WIDTH-bit input
//   q   : d delayed by DEPTH cycles (combinational pass-through if DEPTH=0)
module shift_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/phase_row_cache.sv
// phase_row_cache
// Ping-pong cache of reference phase rows. Rows arrive as AXI-stream beats of
// BEAT_SIZE samples and are assembled into WIN_SIZE-sample cache words in the
// write bank. A completed row is handed to the read side (row_ready) and stays
// stable until the match stage frees it with row_release.
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-high reset
//   s_axis_tdata    : reference beat, lane 0 (LSBs) = lowest row position
//   s_axis_tvalid   : beat valid
//   s_axis_tready   : cache can accept a beat
//   s_axis_tlast    : last beat of the row
//   row_ready       : at least one complete row is readable
//   row_release     : one-cycle pulse, frees the row currently being read
//   cache_addr      : window index to read
//   cache_data      : window contents, READ_LATENCY cycles after cache_addr
//   row_len_err     : one-cycle pulse when a row has the wrong length
module phase_row_cache
  import pmp_pkg::*;
#(
  parameter int ROW_SIZE     = 1280,
  parameter int WIN_SIZE     = 128,
  parameter int BEAT_SIZE    = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BEAT_SIZE*DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic                                  s_axis_tlast,
  output logic                                  row_ready,
  input  logic                                  row_release,
  input  logic [$clog2(ROW_SIZE/WIN_SIZE)-1:0]  cache_addr,
  output logic [WIN_SIZE*DATA_WIDTH-1:0]        cache_data,
  output logic                                  row_len_err
);

  localparam int N_WIN  = calc_n_win(ROW_SIZE, WIN_SIZE);
  localparam int BPW    = calc_bpw(WIN_SIZE, BEAT_SIZE);
  localparam int BPR    = calc_bpr(ROW_SIZE, BEAT_SIZE);
  localparam int CW     = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int IW     = $clog2(2 * N_WIN);
  localparam int SW     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BEAT_W = BEAT_SIZE * DATA_WIDTH;
  localparam int WORD_W = WIN_SIZE * DATA_WIDTH;

  wr_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      full_cnt_q, full_cnt_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic            tready_q, tready_d;
  logic            row_ready_q, row_ready_d;
  logic            err_q, err_d;

  logic            accept;
  logic            last_pos;
  logic            commit;
  logic            release_ok;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [SW-1:0]   wr_slot;
  logic [IW-1:0]   rd_idx;
  logic [WORD_W-1:0] rd_word;

  // Bank b occupies words b*N_WIN .. b*N_WIN+N_WIN-1.
  logic [WORD_W-1:0] mem_q [2*N_WIN];

  assign accept     = s_axis_tvalid & tready_q;
  assign last_pos   = (cnt_q == CW'(BPR - 1));
  assign release_ok = row_release & row_ready_q;

  always_comb begin
    wr_idx  = IW'((int'(cnt_q) / BPW) + (wr_bank_q ? N_WIN : 0));
    wr_slot = SW'(int'(cnt_q) % BPW);
  end

  // Write FSM. Beats are written as they arrive even if the row later turns
  // out malformed: the write bank is never the readable bank, so a discarded
  // row simply gets overwritten by the next one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      W_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (last_pos) begin
            cnt_d = '0;
            if (s_axis_tlast) begin
              commit = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = W_FLUSH;
            end
          end else if (s_axis_tlast) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      W_FLUSH: begin
        if (accept && s_axis_tlast) begin
          cnt_d   = '0;
          state_d = W_LOAD;
        end
      end
      W_FULL: begin
        if (full_cnt_q != 2'd2) begin
          state_d = W_LOAD;
        end
      end
      default: begin
        state_d = W_LOAD;
      end
    endcase

    // A commit and a release in the same cycle cancel in the count but both
    // bank pointers still advance.
    case ({commit, release_ok})
      2'b10:   full_cnt_d = full_cnt_q + 2'd1;
      2'b01:   full_cnt_d = full_cnt_q - 2'd1;
      default: full_cnt_d = full_cnt_q;
    endcase

    if (commit && (full_cnt_d == 2'd2)) begin
      state_d = W_FULL;
    end

    wr_bank_d   = wr_bank_q ^ commit;
    rd_bank_d   = rd_bank_q ^ release_ok;
    row_ready_d = (full_cnt_d != 2'd0);
    tready_d    = (state_d != W_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= W_LOAD;
      cnt_q       <= '0;
      full_cnt_q  <= 2'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      tready_q    <= 1'b0;
      row_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      full_cnt_q  <= full_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      tready_q    <= tready_d;
      row_ready_q <= row_ready_d;
      err_q       <= err_d;
    end
  end

  // Beat-sized partial write into the addressed word; storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int s = 0; s < BPW; s++) begin
        if (wr_slot == SW'(s)) begin
          mem_q[wr_idx][s*BEAT_W +: BEAT_W] <= s_axis_tdata;
        end
      end
    end
  end

  // Out-of-range windows read as zero; the whole latency lives in the pipe.
  always_comb begin
    rd_idx  = IW'(int'(cache_addr) + (rd_bank_q ? N_WIN : 0));
    rd_word = '0;
    if (int'(cache_addr) < N_WIN) begin
      rd_word = mem_q[rd_idx];
    end
  end

  shift_reg #(
    .WIDTH (WORD_W),
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk (clk),
    .rst (rst),
    .d   (rd_word),
    .q   (cache_data)
  );

  assign s_axis_tready = tready_q;
  assign row_ready     = row_ready_q;
  assign row_len_err   = err_q;

endmodule
